ram_stream_reader: RTL
======================

RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 10, RAM address width; DATA_WIDTH, default 16, RAM word width; FIFO_DEPTH, default 4, output buffer entries (power of 2, >=4).
REQ-002 Clocking SHALL be one clock, and reset SHALL be asynchronous and active-low.
REQ-003 clk  in  1  clock, all state on rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 start  in  1  one-cycle request to begin a burst read; sampled only in IDLE.
REQ-006 base_addr  in  ADDR_WIDTH  first word address, sampled with start.
REQ-007 length  in  ADDR_WIDTH+1  word count, 0..2^ADDR_WIDTH, sampled with start.
REQ-008 ram_a  out  ADDR_WIDTH  address to the single-port RAM.
REQ-009 ram_we  out  1  RAM write enable, constant 0.
REQ-010 ram_d  out  DATA_WIDTH  RAM write data, constant 0.
REQ-011 ram_q  in  DATA_WIDTH  RAM read data, registered by the RAM one clock after ram_a.
REQ-012 out_data  out  DATA_WIDTH  streamed word.
REQ-013 out_valid  out  1  out_data valid.
REQ-014 out_ready  in  1  consumer accepts word when out_valid & out_ready.
REQ-015 out_last  out  1  marks the final word of the burst, qualified by out_valid.
REQ-016 busy  out  1  high from the cycle after an accepted start until done.
REQ-017 done  out  1  one-cycle pulse at burst completion.

Function
REQ-018 The state machine SHALL have the states IDLE, RUN (issuing addresses) and DRAIN (all addresses issued, words remaining in flight or buffered).
REQ-019 IDLE->RUN SHALL occur on start with length!=0; IDLE->DRAIN SHALL occur on start with length==0, and done SHALL pulse in the next cycle with no beat emitted.
REQ-020 Start SHALL be ignored outside IDLE; base_addr and length changes during a burst SHALL have no effect.
REQ-021 Address issue SHALL be at most one per cycle, only while (buffer occupancy + reads in flight - pop this cycle) < FIFO_DEPTH.
REQ-022 Reads in flight SHALL count two pipeline stages: address issued, then RAM output register; a word SHALL be written into the buffer two edges after its address is driven.
REQ-023 ram_a SHALL hold its last value when no issue occurs; non-issue cycles SHALL NOT produce buffer writes.
REQ-024 Addresses SHALL increment by 1 modulo 2^ADDR_WIDTH (wrap from all-ones to 0 within a burst).
REQ-025 RUN->DRAIN SHALL occur when the length-th address is issued.
REQ-026 DRAIN->IDLE SHALL occur on the handshake of the out_last word; done SHALL be high and busy low in the following cycle.
REQ-027 Latency from start=1 (cycle 0) SHALL be: ram_a=base_addr in cycle 1, and out_valid first high in cycle 3 when the buffer is empty.
REQ-028 With out_ready held high, throughput SHALL be one word per cycle with no bubbles after the first word.
REQ-029 Under out_ready=0, out_data, out_valid and out_last SHALL remain stable, and no word SHALL be lost or duplicated.
REQ-030 out_last SHALL be asserted only with the length-th word.
REQ-031 A new start SHALL be accepted in the cycle done is high (IDLE).

Reset
REQ-032 On rst_n=0, the block SHALL clear immediately: state IDLE, ram_a=0, buffer empty, in-flight count 0, out_valid=0, out_last=0, busy=0, done=0.
REQ-033 A reset mid-burst SHALL abort the burst with no done pulse; after release the block SHALL accept start normally.

Verification
REQ-034 The bench SHALL cover: RAM preloaded mem[i]=i, base=5, length=4, out_ready=1 -> words 5,6,7,8 in cycles 3..6, out_last on word 8, done in cycle 7.
REQ-035 The bench SHALL cover: base=2^ADDR_WIDTH-2, length=4 -> addresses 1022,1023,0,1, and data in that order.
REQ-036 The bench SHALL cover: length=0 -> no out_valid, done pulse one cycle after start, busy high for exactly one cycle.
REQ-037 The bench SHALL cover: length=16 with out_ready random 50% -> all 16 words in order exactly once, buffer occupancy never exceeding FIFO_DEPTH.
REQ-038 The bench SHALL cover: rst_n pulsed low after 3 accepted words of a 10-word burst -> outputs zero immediately, no done; a following start of length=2 completes correctly.
REQ-039 The bench SHALL cover: start pulsed during a busy burst -> ignored, original burst unchanged.

Source files
------------

// File: rtl/ram_stream_reader_if.sv
// Output word stream of ram_stream_reader: valid/ready handshake with an
// end-of-burst marker.
interface ram_stream_reader_if #(
   parameter int unsigned DATA_WIDTH = 16
);
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_valid;
   logic                  out_ready;
   logic                  out_last;

   modport master (output out_data, output out_valid, output out_last, input out_ready);
   modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/ram_stream_reader.sv
// Burst reader: walks a single-port RAM from base_addr for length words and
// streams them through a small buffer with valid/ready flow control.
module ram_stream_reader #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   length,
   output logic [ADDR_WIDTH-1:0] ram_a,
   output logic                  ram_we,
   output logic [DATA_WIDTH-1:0] ram_d,
   input  logic [DATA_WIDTH-1:0] ram_q,
   ram_stream_reader_if.master   stream,
   output logic                  busy,
   output logic                  done
);
   localparam int unsigned PW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t                state;
   logic [ADDR_WIDTH:0]   remaining;
   logic                  v1, v2, l1, l2;
   logic                  no_beats;
   logic [DATA_WIDTH:0]   mem [FIFO_DEPTH];
   logic [PW-1:0]         wr_ptr, rd_ptr;
   logic [PW:0]           count;
   logic [PW+1:0]         occupancy;
   logic [DATA_WIDTH:0]   head;
   logic                  pop, issue;

   assign ram_we = 1'b0;
   assign ram_d  = '0;

   assign head             = mem[rd_ptr];
   assign stream.out_valid = (count != '0);
   assign stream.out_data  = stream.out_valid ? head[DATA_WIDTH-1:0] : '0;
   assign stream.out_last  = stream.out_valid & head[DATA_WIDTH];

   // Reserve buffer room for words still in the two-stage RAM pipeline.
   always_comb begin
      pop       = stream.out_valid & stream.out_ready;
      occupancy = {1'b0, count} + (PW+2)'(v1) + (PW+2)'(v2) - (PW+2)'(pop);
      issue     = (state == RUN) && (remaining != '0) &&
                  (occupancy < (PW+2)'(FIFO_DEPTH));
   end

   always_ff @(posedge clk) begin
      if (v2) mem[wr_ptr] <= {l2, ram_q};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ram_a     <= '0;
         remaining <= '0;
         v1        <= 1'b0;
         v2        <= 1'b0;
         l1        <= 1'b0;
         l2        <= 1'b0;
         no_beats  <= 1'b0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         v1   <= 1'b0;
         l1   <= 1'b0;
         v2   <= v1;
         l2   <= l1;
         if (v2)  wr_ptr <= wr_ptr + PW'(1);
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         count <= count + (PW+1)'(v2) - (PW+1)'(pop);

         case (state)
            IDLE: begin
               if (start) begin
                  busy     <= 1'b1;
                  no_beats <= (length == '0);
                  if (length != '0) begin
                     // First address goes out on the accepting edge.
                     ram_a     <= base_addr;
                     v1        <= 1'b1;
                     l1        <= (length == (ADDR_WIDTH+1)'(1));
                     remaining <= length - (ADDR_WIDTH+1)'(1);
                     state     <= RUN;
                  end else begin
                     state <= DRAIN;
                  end
               end
            end
            RUN: begin
               if (issue) begin
                  ram_a     <= ram_a + ADDR_WIDTH'(1);
                  v1        <= 1'b1;
                  l1        <= (remaining == (ADDR_WIDTH+1)'(1));
                  remaining <= remaining - (ADDR_WIDTH+1)'(1);
                  if (remaining == (ADDR_WIDTH+1)'(1)) state <= DRAIN;
               end else if (remaining == '0) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (no_beats || (pop && stream.out_last)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
